sram_1r1w_param_bypass: RTL

Parametrised behavioural 1-read/1-write SRAM for cache data/tag arrays. Successor to the fixed-size 1R1W macro model: single clock, configurable width, depth and byte-mask granularity, selectable read latency of 1 or 2, and a same-cycle write-to-read bypass mode. An optional post-reset clear sequencer zeroes the array, with `ready` deasserted until the clear completes. Sits under the L1/L2 cache controllers as the storage primitive.

---
 rtl/sram_1r1w_param_bypass.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/sram_1r1w_param_bypass.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sram_1r1w_param_bypass                                          |
// | Desc     : 1R1W byte-masked SRAM, 1/2-cycle read, write bypass, reset clear |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module sram_1r1w_param_bypass #(
  parameter int DATA_WIDTH    = 128,
  parameter int ADDR_WIDTH    = 7,
  parameter int BYTE_W        = 8,
  parameter int READ_LATENCY  = 1,
  parameter int WRITE_FIRST   = 1,
  parameter int INIT_ON_RESET = 1,
  localparam int NUM_WMASKS   = DATA_WIDTH / BYTE_W
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  ready,
  input  logic                  csb0,
  input  logic [NUM_WMASKS-1:0] wmask0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] din0,
  input  logic                  csb1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  output logic [DATA_WIDTH-1:0] dout1,
  output logic                  dout1_valid,
  output logic                  collision
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] CNT_ONE  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] CNT_LAST = '1;

  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  localparam state_t RESET_STATE = (INIT_ON_RESET != 0) ? ST_INIT : ST_READY;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  wr_acc, rd_acc, same_addr;
  logic [DATA_WIDTH-1:0] wr_old, wr_merged, rd_old, rd_word;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  logic [DATA_WIDTH-1:0] dout1_q, dout1_d;
  logic                  dout1_valid_q, dout1_valid_d;
  logic                  collision_q, collision_d;

  assign ready     = (state_q == ST_READY);
  assign wr_acc    = ready & ~csb0;
  assign rd_acc    = ready & ~csb1;
  assign same_addr = wr_acc & rd_acc & (addr0 == addr1);
  assign wr_old    = mem[addr0];
  assign rd_old    = mem[addr1];

  generate
    for (genvar i = 0; i < NUM_WMASKS; i++) begin : g_lane
      assign wr_merged[i*BYTE_W +: BYTE_W] =
        wmask0[i] ? din0[i*BYTE_W +: BYTE_W] : wr_old[i*BYTE_W +: BYTE_W];
    end
  endgenerate

  // Bypass returns the lane-merged word the write is about to store.
  assign rd_word = ((WRITE_FIRST != 0) && same_addr) ? wr_merged : rd_old;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_we    = wr_acc & (wmask0 != '0);
    mem_waddr = addr0;
    mem_wdata = wr_merged;
    if (state_q == ST_INIT) begin
      mem_we    = 1'b1;
      mem_waddr = cnt_q;
      mem_wdata = '0;
      cnt_d     = cnt_q + CNT_ONE;
      if (cnt_q == CNT_LAST) begin
        state_d = ST_READY;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RESET_STATE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Collision timing is independent of read latency.
  assign collision_d = same_addr;

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic [DATA_WIDTH-1:0] stage_q, stage_d;
      logic                  stage_v_q, stage_v_d;

      always_comb begin
        stage_d   = stage_q;
        stage_v_d = rd_acc;
        if (rd_acc) begin
          stage_d = rd_word;
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          stage_q   <= '0;
          stage_v_q <= 1'b0;
        end else begin
          stage_q   <= stage_d;
          stage_v_q <= stage_v_d;
        end
      end

      assign dout1_valid_d = stage_v_q;
      assign dout1_d       = stage_v_q ? stage_q : dout1_q;
    end else begin : g_lat1
      assign dout1_valid_d = rd_acc;
      assign dout1_d       = rd_acc ? rd_word : dout1_q;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout1_q       <= '0;
      dout1_valid_q <= 1'b0;
      collision_q   <= 1'b0;
    end else begin
      dout1_q       <= dout1_d;
      dout1_valid_q <= dout1_valid_d;
      collision_q   <= collision_d;
    end
  end

  assign dout1       = dout1_q;
  assign dout1_valid = dout1_valid_q;
  assign collision   = collision_q;

endmodule
`default_nettype wire
